// File: rtl/clk_ratio_monitor_pkg.sv
// rtl/clk_ratio_monitor_pkg.sv - shared state encoding and width helper for clk_ratio_monitor
package clk_ratio_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_MEASURE,
        ST_LOCKED
    } mon_state_t;

    function automatic int cw_of(input int max_ratio);
        return $clog2(max_ratio + 1);
    endfunction

endpackage

// File: rtl/clk_ratio_monitor_sync_rise_det.sv
// rtl/clk_ratio_monitor_sync_rise_det.sv - synchronizer and rising-edge detector for a sampled clock
module sync_rise_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_s    = sync_q[SYNC_STAGES-1];
    assign o_rise = sync_q[SYNC_STAGES-1] & ~s_d_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// rtl/clk_ratio_monitor.sv - measures period/high/low of a divided clock in ref cycles, with lock and timeout
module clk_ratio_monitor
    import clk_ratio_monitor_pkg::*;
#(
    parameter  int MAX_RATIO   = 64,
    parameter  int LOCK_CNT    = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = cw_of(MAX_RATIO)
) (
    input  logic          i_ref_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_div_clk,
    input  logic [CW-1:0] i_exp_ratio,
    output logic [CW-1:0] o_ratio,
    output logic [CW-1:0] o_high,
    output logic [CW-1:0] o_low,
    output logic          o_valid,
    output logic          o_locked,
    output logic          o_mismatch,
    output logic          o_timeout
);

    localparam int            EW       = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] MAX_R    = CW'(MAX_RATIO);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [EW-1:0] EQ_ONE   = EW'(1);
    localparam logic [EW-1:0] LOCK_SAT = EW'(LOCK_CNT);
    localparam logic [EW-1:0] LOCK_HIT = EW'(LOCK_CNT - 1);

    mon_state_t    state_q, state_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] ratio_q, ratio_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] low_q, low_d;
    logic [EW-1:0] eqcnt_q, eqcnt_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic          s, rise;
    logic          pcnt_full, same_period, locked;

    sync_rise_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (i_ref_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_div_clk),
        .o_s    (s),
        .o_rise (rise)
    );

    assign pcnt_full   = (pcnt_q == MAX_R);
    assign same_period = (pcnt_q == ratio_q);

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        hcnt_d    = hcnt_q;
        ratio_d   = ratio_q;
        high_d    = high_q;
        low_d     = low_q;
        eqcnt_d   = eqcnt_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!i_en) begin
            state_d   = ST_IDLE;
            pcnt_d    = '0;
            hcnt_d    = '0;
            eqcnt_d   = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ALIGN;
                // pcnt doubles as a wait counter while hunting for the first edge
                ST_ALIGN: begin
                    if (rise) begin
                        pcnt_d  = ONE;
                        hcnt_d  = ONE;
                        state_d = ST_MEASURE;
                    end else if (pcnt_full) begin
                        timeout_d = 1'b1;
                        pcnt_d    = '0;
                        hcnt_d    = '0;
                        eqcnt_d   = '0;
                    end else begin
                        pcnt_d = pcnt_q + ONE;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (rise) begin
                        ratio_d = pcnt_q;
                        high_d  = hcnt_q;
                        low_d   = pcnt_q - hcnt_q;
                        valid_d = 1'b1;
                        pcnt_d  = ONE;
                        hcnt_d  = ONE;
                        if (same_period) begin
                            if (eqcnt_q != LOCK_SAT) eqcnt_d = eqcnt_q + EQ_ONE;
                            if (state_q == ST_MEASURE && eqcnt_d >= LOCK_HIT) state_d = ST_LOCKED;
                        end else begin
                            eqcnt_d = '0;
                            state_d = ST_MEASURE;
                        end
                    end else if (pcnt_full) begin
                        timeout_d = 1'b1;
                        eqcnt_d   = '0;
                        pcnt_d    = '0;
                        hcnt_d    = '0;
                        state_d   = ST_ALIGN;
                    end else begin
                        pcnt_d = pcnt_q + ONE;
                        if (s) hcnt_d = hcnt_q + ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            hcnt_q    <= '0;
            ratio_q   <= '0;
            high_q    <= '0;
            low_q     <= '0;
            eqcnt_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            hcnt_q    <= hcnt_d;
            ratio_q   <= ratio_d;
            high_q    <= high_d;
            low_q     <= low_d;
            eqcnt_q   <= eqcnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign o_ratio    = ratio_q;
    assign o_high     = high_q;
    assign o_low      = low_q;
    assign o_valid    = valid_q;
    assign o_locked   = locked;
    assign o_mismatch = locked && (ratio_q != i_exp_ratio);
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb/tb_clk_ratio_monitor.sv - scoreboard bench for clk_ratio_monitor with random and directed clocks
module tb_clk_ratio_monitor;

    localparam int MAX_RATIO   = 64;
    localparam int LOCK_CNT    = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(MAX_RATIO + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          div_clk = 1'b0;
    logic [CW-1:0] exp_ratio = '0;
    logic [CW-1:0] r_ratio, r_high, r_low;
    logic          r_valid, r_locked, r_mismatch, r_timeout;

    clk_ratio_monitor #(
        .MAX_RATIO  (MAX_RATIO),
        .LOCK_CNT   (LOCK_CNT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_div_clk  (div_clk),
        .i_exp_ratio(exp_ratio),
        .o_ratio    (r_ratio),
        .o_high     (r_high),
        .o_low      (r_low),
        .o_valid    (r_valid),
        .o_locked   (r_locked),
        .o_mismatch (r_mismatch),
        .o_timeout  (r_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ratio;
        int high;
        int low;
        bit locked;
        bit mismatch;
    } exp_t;

    exp_t sb_q[$];
    int   hist[$];
    int   checks = 0;
    int   failures = 0;
    int   m_last = 0;
    int   exp_val = 0;
    int   m_prev_h = 0;
    int   m_prev_l = 0;
    bit   m_have_prev = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Locked means the last LOCK_CNT periods (seeded with the held ratio) are all equal
    function automatic bit run_locked();
        int n = hist.size();
        if (n < LOCK_CNT) return 1'b0;
        for (int i = 1; i < LOCK_CNT; i++)
            if (hist[n-1-i] != hist[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_close(input int h, input int l);
        exp_t e;
        hist.push_back(h + l);
        m_last     = h + l;
        e.ratio    = h + l;
        e.high     = h;
        e.low      = l;
        e.locked   = run_locked();
        e.mismatch = e.locked && (e.ratio != exp_val);
        sb_q.push_back(e);
    endtask

    task automatic model_restart();
        hist.delete();
        hist.push_back(m_last);
        m_have_prev = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_period(input int h, input int l);
        if (m_have_prev) model_close(m_prev_h, m_prev_l);
        m_have_prev = 1'b1;
        m_prev_h    = h;
        m_prev_l    = l;
        div_clk = 1'b1;
        tick(h);
        div_clk = 1'b0;
        tick(l);
    endtask

    task automatic start_run(input int expv);
        exp_val   = expv;
        exp_ratio = CW'(expv);
        en        = 1'b1;
        model_restart();
        tick(2);
    endtask

    task automatic end_run();
        tick(6);
        check("drain", sb_q.size(), 0);
        en = 1'b0;
        tick(3);
        check("idle_locked", int'(r_locked), 0);
        check("idle_timeout", int'(r_timeout), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ratio"}, int'(r_ratio), 0);
        check({tag, "_high"}, int'(r_high), 0);
        check({tag, "_low"}, int'(r_low), 0);
        check({tag, "_valid"}, int'(r_valid), 0);
        check({tag, "_locked"}, int'(r_locked), 0);
        check({tag, "_mismatch"}, int'(r_mismatch), 0);
        check({tag, "_timeout"}, int'(r_timeout), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && r_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("ratio", int'(r_ratio), e.ratio);
                check("high", int'(r_high), e.high);
                check("low", int'(r_low), e.low);
                check("locked", int'(r_locked), int'(e.locked));
                check("mismatch", int'(r_mismatch), int'(e.mismatch));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        start_run(6);
        repeat (6) drive_period(3, 3);
        end_run();

        start_run(6);
        repeat (6) drive_period(2, 3);
        tick(6);
        check("mismatch_level", int'(r_mismatch), 1);
        exp_ratio = CW'(5);
        #1;
        check("mismatch_follows_exp", int'(r_mismatch), 0);
        end_run();

        start_run(4);
        repeat (6) drive_period(3, 3);
        repeat (6) drive_period(2, 2);
        end_run();

        start_run(2);
        repeat (6) drive_period(1, 1);
        end_run();

        // Stuck-low clock from ALIGN
        start_run(6);
        t = 0;
        while (!r_timeout && t < 200) begin
            tick(1);
            t++;
        end
        check("timeout_latency_ok", int'(t >= 63 && t <= 68), 1);
        tick(100);
        check("timeout_sticky", int'(r_timeout), 1);
        en = 1'b0;
        tick(1);
        check("timeout_cleared", int'(r_timeout), 0);
        tick(2);

        // Clock stops while locked, then resumes at a new ratio
        start_run(6);
        repeat (5) drive_period(3, 3);
        tick(6);
        check("locked_before_stop", int'(r_locked), 1);
        tick(70);
        check("timeout_from_locked", int'(r_timeout), 1);
        check("unlocked_after_timeout", int'(r_locked), 0);
        model_restart();
        repeat (5) drive_period(2, 2);
        tick(6);
        check("drain_after_timeout", sb_q.size(), 0);
        en = 1'b0;
        tick(3);

        // Asynchronous reset in the middle of a high phase
        start_run(6);
        repeat (3) drive_period(3, 3);
        model_close(m_prev_h, m_prev_l);
        div_clk = 1'b1;
        tick(5);
        check("drain_before_reset", sb_q.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        div_clk = 1'b0;
        tick(2);
        rst_n = 1'b1;
        m_last = 0;
        model_restart();
        tick(2);
        repeat (5) drive_period(3, 3);
        end_run();

        for (int run = 0; run < 6; run++) begin
            start_run(int'($urandom_range(2, 12)));
            for (int seg = 0; seg < 3; seg++) begin
                int h = int'($urandom_range(1, 6));
                int l = int'($urandom_range(1, 6));
                int r = int'($urandom_range(1, 6));
                repeat (r) drive_period(h, l);
            end
            end_run();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
